sample_serializer: RTL and testbench
====================================

SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 The module SHALL have parameter SAMPLE_COUNT, default 8, giving the number of samples per frame (legal 1..8).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the width of each signed sample.
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst  input  1  is the reset; it SHALL be synchronous and active-low (rst=0 sampled at a rising clk edge resets).
REQ-005 Port load  input  1  requests capture of a parallel frame.
REQ-006 Ports C0..C7  input  DATA_W each  carry the signed parallel samples, C0 first in the stream.
REQ-007 Port load_ready  output  1  indicates that a frame is accepted this cycle if load=1.
REQ-008 Port out_data  output  DATA_W  carries the current signed serial sample.
REQ-009 Port out_valid  output  1  marks out_data as valid.
REQ-010 Port out_ready  input  1  is the downstream acceptance signal.
REQ-011 Port out_idx  output  3  gives the index (0..SAMPLE_COUNT-1) of the current sample.
REQ-012 Port out_last  output  1  flags the final sample of a frame.
REQ-013 Port frame_cnt  output  8  counts completed frames.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-015 A load SHALL be accepted when load=1 and load_ready=1 at a rising edge; C0..C(SAMPLE_COUNT-1) SHALL be captured into an internal frame buffer on that edge.
REQ-016 load_ready SHALL be 1 in IDLE, and 1 in SEND only during the cycle in which the last beat completes (out_valid & out_ready & out_last); otherwise it SHALL be 0.
REQ-017 Inputs C0..C7 SHALL be ignored on every edge except an accepting edge, so a later change cannot alter a frame in flight.
REQ-018 On acceptance the FSM SHALL go to SEND with out_idx=0, and out_valid=1 SHALL appear on the next cycle (latency 1 cycle, load edge to first valid).
REQ-019 In SEND, out_data SHALL equal buffer[out_idx]; out_last SHALL equal (out_idx==SAMPLE_COUNT-1) while out_valid=1, and 0 otherwise.
REQ-020 A beat SHALL complete on any edge with out_valid=1 and out_ready=1; out_idx SHALL then increment by 1.
REQ-021 When out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable, and out_valid SHALL stay 1 (no retraction).
REQ-022 On completion of the last beat with no simultaneous load, the FSM SHALL return to IDLE and out_valid SHALL drop to 0 on the next cycle.
REQ-023 On completion of the last beat with a simultaneous load, the new frame SHALL be captured and the FSM SHALL stay in SEND with out_idx=0, out_valid=1 the next cycle (zero bubble).
REQ-024 frame_cnt SHALL increment by 1 on each last-beat completion and SHALL wrap from 255 to 0.
REQ-025 With SAMPLE_COUNT=1, every beat SHALL be a last beat, and out_idx SHALL remain 0.
REQ-026 Samples SHALL pass through bit-exact, with no sign extension, truncation or reordering.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE with out_valid=0, out_last=0, out_idx=0, out_data=0, frame_cnt=0, load_ready=1 after release, and the buffer cleared to 0.
REQ-028 Reset SHALL take priority over load and out_ready on the same edge.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; no further beats of that frame SHALL be emitted and frame_cnt SHALL NOT increment for it.

Verification
REQ-030 Load C0..C7 = 0x01,0x02,..,0x08 with out_ready held 1 -> out_data 0x01..0x08 on 8 consecutive cycles, out_last only on 0x08, frame_cnt=1, out_valid=0 after.
REQ-031 Load 0x80,0xFF,0x7F,0x00,... with out_ready toggling 1,0,1,0 -> every sample is held while stalled, the byte order is unchanged, and 0x80/0xFF come out unmodified.
REQ-032 Load frame A, change C inputs mid-frame, then load frame B on A's last beat -> all of A is emitted unchanged, followed immediately by B[0] with no idle cycle.
REQ-033 Drive rst=0 after 3 beats of a frame -> the next cycle shows out_valid=0, out_idx=0, frame_cnt=0, and a subsequent load starts cleanly at index 0.
REQ-034 Stream 256 frames -> frame_cnt wraps to 0; with load=1 and load_ready=0 mid-frame, no capture occurs.
REQ-035 Run with SAMPLE_COUNT=1 -> each load yields exactly one beat with out_last=1 and out_idx=0.

Source files
------------

// File: rtl/sample_serializer.sv
// sample_serializer: captures a parallel frame of signed samples and streams
// them out one per beat over a valid/ready handshake, C0 first.
module sample_serializer #(
   parameter int unsigned SAMPLE_COUNT = 8,
   parameter int unsigned DATA_W       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic signed [DATA_W-1:0] C0,
   input  logic signed [DATA_W-1:0] C1,
   input  logic signed [DATA_W-1:0] C2,
   input  logic signed [DATA_W-1:0] C3,
   input  logic signed [DATA_W-1:0] C4,
   input  logic signed [DATA_W-1:0] C5,
   input  logic signed [DATA_W-1:0] C6,
   input  logic signed [DATA_W-1:0] C7,
   output logic                     load_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_idx,
   output logic                     out_last,
   output logic [7:0]               frame_cnt
);

   localparam int unsigned  BUF_DEPTH = 8;
   localparam int unsigned  IDX_W     = 3;
   localparam int unsigned  CNT_W     = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLE_COUNT - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [DATA_W-1:0] buf_q [BUF_DEPTH];
   logic signed [DATA_W-1:0] buf_d [BUF_DEPTH];

   logic beat_c;
   logic last_beat_c;
   logic accept_c;

   // Handshake decode: a beat completes on valid & ready; a load is taken
   // whenever the frame buffer is free at this edge.
   always_comb begin
      beat_c      = (state_q == S_SEND) && out_ready;
      last_beat_c = beat_c && (idx_q == LAST_IDX);
      load_ready  = (state_q == S_IDLE) || last_beat_c;
      accept_c    = load && load_ready;
   end

   // Next-state logic: capture on accept, advance on beat, wrap on last beat.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               state_d = S_SEND;
               idx_d   = '0;
            end
         end
         S_SEND: begin
            if (last_beat_c) begin
               cnt_d   = cnt_q + CNT_W'(1);
               idx_d   = '0;
               state_d = load ? S_SEND : S_IDLE;
            end else if (beat_c) begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
      if (accept_c) begin
         buf_d[0] = C0;
         buf_d[1] = C1;
         buf_d[2] = C2;
         buf_d[3] = C3;
         buf_d[4] = C4;
         buf_d[5] = C5;
         buf_d[6] = C6;
         buf_d[7] = C7;
      end
   end

   // State registers with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
      end
   end

   // Output views of the registered state.
   always_comb begin
      out_valid = (state_q == S_SEND);
      out_idx   = idx_q;
      out_last  = out_valid && (idx_q == LAST_IDX);
      out_data  = buf_q[idx_q];
      frame_cnt = cnt_q;
   end

endmodule

// File: tb/tb_sample_serializer.sv
// tb_sample_serializer: randomized bench comparing two serializer instances
// (8 samples/frame and 1 sample/frame) against a queue-based reference model.
module tb_sample_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic       out_ready;
   logic [7:0] c [8];

   logic       a_lr, a_valid, a_last;
   logic [7:0] a_data, a_cnt;
   logic [2:0] a_idx;
   logic       b_lr, b_valid, b_last;
   logic [7:0] b_data, b_cnt;
   logic [2:0] b_idx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sample_serializer #(.SAMPLE_COUNT(8), .DATA_W(8)) u_dut8 (
      .clk(clk), .rst(rst), .load(load),
      .C0(c[0]), .C1(c[1]), .C2(c[2]), .C3(c[3]),
      .C4(c[4]), .C5(c[5]), .C6(c[6]), .C7(c[7]),
      .load_ready(a_lr), .out_data(a_data), .out_valid(a_valid),
      .out_ready(out_ready), .out_idx(a_idx), .out_last(a_last),
      .frame_cnt(a_cnt)
   );

   sample_serializer #(.SAMPLE_COUNT(1), .DATA_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .load(load),
      .C0(c[0]), .C1(c[1]), .C2(c[2]), .C3(c[3]),
      .C4(c[4]), .C5(c[5]), .C6(c[6]), .C7(c[7]),
      .load_ready(b_lr), .out_data(b_data), .out_valid(b_valid),
      .out_ready(out_ready), .out_idx(b_idx), .out_last(b_last),
      .frame_cnt(b_cnt)
   );

   // Reference model: per instance, a queue of pending output beats.
   logic [7:0] md [2][16];
   logic [2:0] mi [2][16];
   logic       ml [2][16];
   int         mn [2];
   logic [7:0] mcnt [2];
   bit         mclean [2];

   function automatic int sc_of(input int m);
      return (m == 0) ? 8 : 1;
   endfunction

   function automatic logic exp_lr(input int m);
      return (mn[m] == 0) || (out_ready && ml[m][0]);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_model(input int m, input logic lr, input logic valid,
                              input logic [7:0] data, input logic [2:0] idx,
                              input logic last, input logic [7:0] cnt);
      string p;
      p = (m == 0) ? "sc8" : "sc1";
      check({p, ".out_valid"}, 32'(valid), 32'(mn[m] > 0));
      check({p, ".load_ready"}, 32'(lr), 32'(exp_lr(m)));
      check({p, ".frame_cnt"}, 32'(cnt), 32'(mcnt[m]));
      if (mn[m] > 0) begin
         check({p, ".out_data"}, 32'(data), 32'(md[m][0]));
         check({p, ".out_idx"}, 32'(idx), 32'(mi[m][0]));
         check({p, ".out_last"}, 32'(last), 32'(ml[m][0]));
      end else begin
         check({p, ".out_last_idle"}, 32'(last), 32'd0);
      end
      if (mclean[m]) begin
         check({p, ".idx_after_rst"}, 32'(idx), 32'd0);
         check({p, ".data_after_rst"}, 32'(data), 32'd0);
      end
   endtask

   task automatic model_edge(input int m);
      logic acc;
      if (!rst) begin
         mn[m]     = 0;
         mcnt[m]   = 8'd0;
         mclean[m] = 1'b1;
      end else begin
         acc = load && exp_lr(m);
         if (mn[m] > 0 && out_ready) begin
            if (ml[m][0]) mcnt[m] = mcnt[m] + 8'd1;
            for (int k = 0; k < 15; k++) begin
               md[m][k] = md[m][k+1];
               mi[m][k] = mi[m][k+1];
               ml[m][k] = ml[m][k+1];
            end
            mn[m]--;
         end
         if (acc) begin
            for (int k = 0; k < sc_of(m); k++) begin
               md[m][mn[m]] = c[k];
               mi[m][mn[m]] = 3'(k);
               ml[m][mn[m]] = (k == sc_of(m) - 1);
               mn[m]++;
            end
            mclean[m] = 1'b0;
         end
      end
   endtask

   // One cycle: inputs already driven after negedge; check, then clock.
   task automatic step();
      #1;
      check_model(0, a_lr, a_valid, a_data, a_idx, a_last, a_cnt);
      check_model(1, b_lr, b_valid, b_data, b_idx, b_last, b_cnt);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
   endtask

   task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input logic [7:0] b7);
      c[0] = b0; c[1] = b1; c[2] = b2; c[3] = b3;
      c[4] = b4; c[5] = b5; c[6] = b6; c[7] = b7;
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 8; k++) c[k] = 8'($urandom);
   endtask

   initial begin
      rst = 1'b0; load = 1'b0; out_ready = 1'b0;
      set_frame(8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA);
      for (int m = 0; m < 2; m++) begin
         mn[m] = 0; mcnt[m] = 8'd0; mclean[m] = 1'b1;
      end
      @(negedge clk);
      // Reset, with load and out_ready asserted to show reset priority.
      load = 1'b1; out_ready = 1'b1;
      step(); step();
      rst = 1'b1; load = 1'b0;
      step();

      // Incrementing frame, out_ready held high.
      set_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08);
      load = 1'b1; step();
      load = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Extreme values with out_ready toggling.
      set_frame(8'h80, 8'hFF, 8'h7F, 8'h00, 8'h81, 8'hFE, 8'h01, 8'h55);
      load = 1'b1; out_ready = 1'b0; step();
      load = 1'b0;
      for (int i = 0; i < 20; i++) begin
         out_ready = i[0];
         step();
      end
      out_ready = 1'b1;
      step();

      // Frame A, inputs scrambled mid-frame, frame B loaded on A's last beat.
      set_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88);
      load = 1'b1; step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin rand_frame(); step(); end
      set_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7);
      load = 1'b1;
      for (int i = 0; i < 5; i++) step();
      load = 1'b0;
      for (int i = 0; i < 10; i++) begin rand_frame(); step(); end

      // Reset after three beats of a frame, then a clean restart.
      rand_frame(); load = 1'b1; step();
      load = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0; step();
      rst = 1'b1; step();
      rand_frame(); load = 1'b1; step();
      load = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // 256+ back-to-back frames so frame_cnt wraps; load held high throughout.
      load = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 256 * 8 + 4; i++) begin rand_frame(); step(); end
      load = 1'b0;
      for (int i = 0; i < 10; i++) step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rand_frame();
         load      = ($urandom % 3) != 0;
         out_ready = ($urandom % 4) != 0;
         rst       = ($urandom % 150) != 0;
         step();
      end
      rst = 1'b1; load = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
